// File: rtl/seq_pkg.sv
// Shared definitions for the serial frame transmitter: one-hot FSM state
// codes, the state-vector width, the default header and a counter-width helper.
package seq_pkg;

  localparam int STATE_W = 5;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 5'b00001,
    ST_HDR   = 5'b00010,
    ST_DATA  = 5'b00100,
    ST_PAR   = 5'b01000,
    ST_GUARD = 5'b10000
  } state_e;

  localparam logic [2:0] HDR_101 = 3'b101;

  // Bit counter width: clog2 of the longer of header and payload, at least 1.
  function automatic int cnt_width(input int hdr_w, input int data_w);
    int m;
    m = (hdr_w > data_w) ? hdr_w : data_w;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/seq_tx_piso.sv
// Parallel-in/serial-out shift register. Load wins over shift; msb is the
// bit that will be sent next.
module seq_tx_piso #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] d,
  output logic         msb
);

  logic [W-1:0] shreg_q;

  // Shift register: load a new word or shift left by one, zero-filling.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_q <= '0;
    end else if (load) begin
      shreg_q <= d;
    end else if (shift) begin
      shreg_q <= shreg_q << 1;
    end
  end

  assign msb = shreg_q[W-1];

endmodule

// File: rtl/seq_tx.sv
// Serial frame transmitter: header, data MSB-first, optional even parity,
// then one guard '0'. Idle line is '0'.
//
// Handshake: start is accepted on a rising edge where start && ready; ready
// is high only in IDLE and equals ~busy. A start while busy is dropped.
//
// dout/busy/done are registered and computed from the next state, so they
// change on the same edge as the state register.
module seq_tx
  import seq_pkg::*;
#(
  parameter int                DATA_W = 8,
  parameter int                HDR_W  = 3,
  parameter logic [HDR_W-1:0]  HDR    = HDR_W'(HDR_101),
  parameter int                PAR_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  output logic              dout,
  output logic              busy,
  output logic              ready,
  output logic              done,
  output logic [STATE_W-1:0] state_dbg
);

  localparam int CNT_W = cnt_width(HDR_W, DATA_W);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic                dout_q, dout_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                load;
  logic                shift;
  logic                msb;
  logic                hdr_bit;

  seq_tx_piso #(.W(DATA_W)) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .d     (din),
    .msb   (msb)
  );

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    din_d   = din_q;
    load    = 1'b0;
    shift   = 1'b0;
    dout_d  = 1'b0;
    done_d  = 1'b0;
    hdr_bit = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_HDR;
          cnt_d   = CNT_W'(HDR_W - 1);
          din_d   = din;
          load    = 1'b1;
        end
      end
      ST_HDR: begin
        if (cnt_q == '0) begin
          state_d = ST_DATA;
          cnt_d   = CNT_W'(DATA_W - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          state_d = (PAR_EN != 0) ? ST_PAR : ST_GUARD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_PAR: begin
        state_d = ST_GUARD;
      end
      ST_GUARD: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Output for the cycle about to begin, selected by the state we enter.
    hdr_bit = |(HDR & (HDR_W'(1) << cnt_d));
    case (state_d)
      ST_HDR:   dout_d = hdr_bit;
      ST_DATA: begin
        // Take the current MSB and advance the register on the same edge.
        dout_d = msb;
        shift  = 1'b1;
      end
      ST_PAR:   dout_d = ^din_q;
      ST_GUARD: done_d = 1'b1;
      default:  dout_d = 1'b0;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, counter, latched payload and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      din_q   <= '0;
      dout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign dout      = dout_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ready     = ~busy_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_seq_tx.sv
// Bench for seq_tx: two instances (8-bit payload with parity, 4-bit payload
// without). Drivers push whole expected frames into per-instance queues on
// acceptance; monitors pop one entry per busy cycle and compare.
module tb_seq_tx;

  localparam int LEN_A = 3 + 8 + 1 + 1;
  localparam int LEN_B = 3 + 4 + 0 + 1;

  logic       clk;
  logic       rst;
  logic       start_a, start_b;
  logic [7:0] din_a;
  logic [3:0] din_b;
  logic       dout_a, busy_a, ready_a, done_a;
  logic       dout_b, busy_b, ready_b, done_b;
  logic [4:0] state_a, state_b;

  int n_pass = 0;
  int n_tot  = 0;

  logic [1:0] exp_a[$];
  logic [1:0] exp_b[$];
  int         a_wait = 0;
  int         b_wait = 0;
  logic [1:0] e_a, e_b;
  logic [2:0] hist_a = '0;
  int         pos_a = 0;

  seq_tx u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .din(din_a),
    .dout(dout_a), .busy(busy_a), .ready(ready_a), .done(done_a),
    .state_dbg(state_a)
  );

  seq_tx #(.DATA_W(4), .PAR_EN(0)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .din(din_b),
    .dout(dout_b), .busy(busy_b), .ready(ready_b), .done(done_b),
    .state_dbg(state_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: a frame is a list of {done, dout} pairs.
  task automatic push_frame(input int which, input logic [7:0] d, input int dw, input bit pe);
    logic [1:0] f[$];
    logic [2:0] hdr_v;
    hdr_v = 3'b101;
    for (int i = 2; i >= 0; i--) f.push_back({1'b0, hdr_v[i]});
    for (int i = dw - 1; i >= 0; i--) f.push_back({1'b0, d[i]});
    if (pe) f.push_back({1'b0, (($countones(d) % 2) == 1) ? 1'b1 : 1'b0});
    f.push_back(2'b10);
    foreach (f[i]) begin
      if (which == 0) exp_a.push_back(f[i]);
      else            exp_b.push_back(f[i]);
    end
  endtask

  // driver tasks: one clock cycle each
  task automatic drive_a(input bit s, input logic [7:0] d);
    @(negedge clk);
    start_a = s;
    din_a   = d;
    check("a_ready_model", ready_a, (a_wait == 0));
    @(posedge clk);
    if (s && a_wait == 0) begin
      push_frame(0, d, 8, 1'b1);
      a_wait = LEN_A;
    end else if (a_wait > 0) begin
      a_wait--;
    end
  endtask

  task automatic drive_b(input bit s, input logic [3:0] d);
    @(negedge clk);
    start_b = s;
    din_b   = d;
    check("b_ready_model", ready_b, (b_wait == 0));
    @(posedge clk);
    if (s && b_wait == 0) begin
      push_frame(1, {4'b0, d}, 4, 1'b0);
      b_wait = LEN_B;
    end else if (b_wait > 0) begin
      b_wait--;
    end
  endtask

  // scoreboard monitor, instance A
  always @(negedge clk) begin
    check("a_ready_eq_nbusy", ready_a, !busy_a);
    check("a_state_onehot", $onehot(state_a), 1);
    if (busy_a) begin
      if (exp_a.size() == 0) begin
        n_tot++;
        $display("FAIL a_extra_bit: got busy=1 dout=%0b done=%0b expected idle", dout_a, done_a);
      end else begin
        e_a = exp_a.pop_front();
        check("a_bit", {done_a, dout_a}, e_a);
        hist_a = {hist_a[1:0], dout_a};
        pos_a++;
        if (pos_a == 3) check("a_det101", hist_a, 3'b101);
      end
    end else begin
      check("a_idle_out", {done_a, dout_a}, 0);
      check("a_idle_queue", exp_a.size(), 0);
      pos_a  = 0;
      hist_a = '0;
    end
  end

  // scoreboard monitor, instance B
  always @(negedge clk) begin
    check("b_ready_eq_nbusy", ready_b, !busy_b);
    if (busy_b) begin
      if (exp_b.size() == 0) begin
        n_tot++;
        $display("FAIL b_extra_bit: got busy=1 dout=%0b done=%0b expected idle", dout_b, done_b);
      end else begin
        e_b = exp_b.pop_front();
        check("b_bit", {done_b, dout_b}, e_b);
      end
    end else begin
      check("b_idle_out", {done_b, dout_b}, 0);
      check("b_idle_queue", exp_b.size(), 0);
    end
  end

  initial begin
    rst     = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    din_a   = '0;
    din_b   = '0;
    #3;
    check("rst_dout", dout_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_ready", ready_a, 1);
    check("rst_done", done_a, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // quiet line after reset
    repeat (20) drive_a(1'b0, 8'($urandom_range(0, 255)));

    // single frames; din scrambled after acceptance
    drive_a(1'b1, 8'hA5);
    repeat (14) drive_a(1'b0, 8'($urandom_range(0, 255)));
    drive_a(1'b1, 8'h07);
    repeat (14) drive_a(1'b0, 8'($urandom_range(0, 255)));

    // start held high: back-to-back frames
    drive_a(1'b1, 8'hFF);
    repeat (30) drive_a(1'b1, 8'h00);
    repeat (14) drive_a(1'b0, 8'h00);

    // reset during data bit 4
    drive_a(1'b1, 8'hFF);
    repeat (6) drive_a(1'b0, 8'h00);
    #2;
    check("pre_rst_dout", dout_a, 1);
    rst = 1'b0;
    #1;
    check("midrst_dout", dout_a, 0);
    check("midrst_busy", busy_a, 0);
    check("midrst_done", done_a, 0);
    exp_a.delete();
    a_wait = 0;
    start_a = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    drive_a(1'b1, 8'h3C);
    repeat (14) drive_a(1'b0, 8'h00);

    // randomized traffic
    repeat (300) drive_a(($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)));
    start_a = 1'b0;

    // 4-bit payload, no parity
    drive_b(1'b1, 4'hC);
    repeat (9) drive_b(1'b0, 4'($urandom_range(0, 15)));
    repeat (150) drive_b(($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)));
    start_b = 1'b0;

    // drain with a bounded wait
    for (int i = 0; i < 40; i++) begin
      if (exp_a.size() == 0 && exp_b.size() == 0 && !busy_a && !busy_b) break;
      @(negedge clk);
    end
    check("drain_a", exp_a.size(), 0);
    check("drain_b", exp_b.size(), 0);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
